// File: rtl/truth_table_checker.sv
// truth_table_checker: steps every input combination through a combinational
// DUT, holds each vector for SETTLE+1 cycles, samples the DUT response on the
// last cycle and compares it against the expected truth table EXP_TT.
module truth_table_checker #(
  parameter int                    N_IN   = 3,
  parameter logic [(2**N_IN)-1:0]  EXP_TT = 8'b1110_1000,
  parameter int                    SETTLE = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic [N_IN-1:0]          abc_out,
  input  logic                     f_in,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [(2**N_IN)-1:0]     captured_tt,
  output logic [N_IN:0]            err_count,
  output logic [N_IN-1:0]          first_err_idx
);

  localparam int V  = 2**N_IN;
  // Settle counter must hold 0..SETTLE; keep at least one bit when SETTLE=0.
  localparam int CW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

  localparam logic [CW-1:0]   SETTLE_C = CW'(SETTLE);
  localparam logic [CW-1:0]   CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1'b1);
  localparam logic [N_IN-1:0] ABC_ZERO = {N_IN{1'b0}};
  localparam logic [N_IN-1:0] ABC_ONE  = N_IN'(1'b1);
  localparam logic [N_IN-1:0] LAST_VEC = {N_IN{1'b1}};
  localparam logic [N_IN:0]   ERR_ZERO = {(N_IN+1){1'b0}};
  localparam logic [N_IN:0]   ERR_ONE  = (N_IN+1)'(1'b1);
  localparam logic [V-1:0]    TT_ZERO  = {V{1'b0}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t            state_r, state_n_s;
  logic [N_IN-1:0]   abc_r, abc_n_s;
  logic [CW-1:0]     cnt_r, cnt_n_s;
  logic [V-1:0]      captured_r, captured_n_s;
  logic [N_IN:0]     err_r, err_n_s;
  logic [N_IN-1:0]   first_r, first_n_s;
  logic              pass_r, pass_n_s;
  logic              busy_r, busy_n_s;
  logic              done_r, done_n_s;

  // True when the sampled response disagrees with the expected table entry.
  function automatic logic is_mismatch(input logic sample, input logic [N_IN-1:0] idx);
    return (sample != EXP_TT[idx]);
  endfunction

  // State and result registers; reset clears everything, including partial results.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= S_IDLE;
      abc_r      <= ABC_ZERO;
      cnt_r      <= CNT_ZERO;
      captured_r <= TT_ZERO;
      err_r      <= ERR_ZERO;
      first_r    <= ABC_ZERO;
      pass_r     <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_n_s;
      abc_r      <= abc_n_s;
      cnt_r      <= cnt_n_s;
      captured_r <= captured_n_s;
      err_r      <= err_n_s;
      first_r    <= first_n_s;
      pass_r     <= pass_n_s;
      busy_r     <= busy_n_s;
      done_r     <= done_n_s;
    end
  end

  // Next-state and result update: run launch, per-vector sampling, run completion.
  always_comb begin
    state_n_s    = state_r;
    abc_n_s      = abc_r;
    cnt_n_s      = cnt_r;
    captured_n_s = captured_r;
    err_n_s      = err_r;
    first_n_s    = first_r;
    pass_n_s     = pass_r;
    busy_n_s     = busy_r;
    done_n_s     = 1'b0;
    case (state_r)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_n_s    = S_DRIVE;
          busy_n_s     = 1'b1;
          abc_n_s      = ABC_ZERO;
          cnt_n_s      = CNT_ZERO;
          captured_n_s = TT_ZERO;
          err_n_s      = ERR_ZERO;
          first_n_s    = ABC_ZERO;
          pass_n_s     = 1'b0;
        end else begin
          state_n_s    = state_r;
        end
      end
      S_DRIVE: begin
        if (cnt_r == SETTLE_C) begin
          // Last cycle of this vector: sample, score and move on.
          captured_n_s[abc_r] = f_in;
          cnt_n_s             = CNT_ZERO;
          if (is_mismatch(f_in, abc_r)) begin
            err_n_s = err_r + ERR_ONE;
            if (err_r == ERR_ZERO) begin
              first_n_s = abc_r;
            end else begin
              first_n_s = first_r;
            end
          end else begin
            err_n_s = err_r;
          end
          if (abc_r == LAST_VEC) begin
            // Final vector: finish the run, stimulus parks at vector 0.
            state_n_s = S_DONE;
            busy_n_s  = 1'b0;
            done_n_s  = 1'b1;
            abc_n_s   = ABC_ZERO;
            pass_n_s  = (err_n_s == ERR_ZERO);
          end else begin
            abc_n_s   = abc_r + ABC_ONE;
          end
        end else begin
          cnt_n_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_n_s = S_IDLE;
        busy_n_s  = 1'b0;
        abc_n_s   = ABC_ZERO;
        cnt_n_s   = CNT_ZERO;
      end
    endcase
  end

  assign abc_out       = abc_r;
  assign busy          = busy_r;
  assign done          = done_r;
  assign pass          = pass_r;
  assign captured_tt   = captured_r;
  assign err_count     = err_r;
  assign first_err_idx = first_r;

endmodule
